// File: rtl/lfsr_ber_monitor.sv
// lfsr_ber_monitor: windowed bit-error counter with threshold alarm, saturating total and lock-loss count
module lfsr_ber_monitor #(
    parameter int WINDOW  = 256,
    parameter int ERR_THR = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic             i_lock,
    input  logic [7:0]       i_rx,
    input  logic [7:0]       i_ref,
    output logic             o_meas_active,
    output logic             o_win_done,
    output logic [CNT_W-1:0] o_win_err,
    output logic             o_alarm,
    output logic [CNT_W-1:0] o_total_err,
    output logic [7:0]       o_lock_loss
);
    localparam int SW = $clog2(WINDOW);
    typedef enum logic {IDLE, MEASURE} state_t;
    state_t           state;
    logic [SW-1:0]    cnt;
    logic [CNT_W-1:0] acc, win;
    logic [3:0]       pop;
    logic [CNT_W:0]   sum;
    always_comb begin
        pop = '0;
        for (int i = 0; i < 8; i++) pop = pop + 4'(i_rx[i] ^ i_ref[i]);
        win = acc + CNT_W'(pop);
        sum = {1'b0, o_total_err} + {1'b0, win};
    end
    assign o_meas_active = (state == MEASURE);
    // lock loss outranks a completing sample; the partial window is dropped
    always_ff @(posedge clk) begin
        if (i_rst || i_clear) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            o_win_done  <= 1'b0;
            o_win_err   <= '0;
            o_alarm     <= 1'b0;
            o_total_err <= '0;
            o_lock_loss <= '0;
        end else begin
            o_win_done <= 1'b0;
            state      <= i_lock ? MEASURE : IDLE;
            if (state == MEASURE && !i_lock) begin
                cnt <= '0;
                acc <= '0;
                if (o_lock_loss != 8'hFF) o_lock_loss <= o_lock_loss + 8'd1;
            end else if (state == MEASURE && i_valid) begin
                if (cnt == SW'(WINDOW - 1)) begin
                    cnt         <= '0;
                    acc         <= '0;
                    o_win_done  <= 1'b1;
                    o_win_err   <= win;
                    o_alarm     <= win > CNT_W'(ERR_THR);
                    o_total_err <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
                end else begin
                    cnt <= cnt + 1'b1;
                    acc <= win;
                end
            end
        end
    end
endmodule
